cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step controller for the RV32I core.
- Consumes the one-cycle step pulse from the button edge stage and the run switch level.
- Produces the CPU clock-enable, so the core can free-run, single-step, or halt at a PC breakpoint.
- Sits between the board input conditioning (edge detector) and the CPU datapath enable; exposes status to the debug display.

Parameters:
- STEP_CYCLES, 1, clock cycles cpu_en is held high per step pulse (1 for single-cycle core; range 1..255).
- CNT_W, 32, width of the enabled-cycle counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  run switch level; 1 = free-run request.
- step_pulse  input  1  one-cycle pulse from the edge detector; requests one step.
- brk_en  input  1  breakpoint enable.
- brk_addr  input  32  breakpoint PC.
- pc  input  32  current CPU PC (registered inside CPU).
- cpu_en  output  1  CPU clock enable (combinational, see below).
- brk_hit  output  1  1 while halted at breakpoint.
- state  output  2  encoded FSM state: 0 PAUSE, 1 RUN, 2 STEP, 3 BRK.
- en_cnt  output  CNT_W  count of cycles with cpu_en=1.

Behaviour:
- Reset (async): state=PAUSE, step counter=0, resume_mask=0, en_cnt=0, brk_hit=0; cpu_en=0 during and after reset.
- brk_match = brk_en & (pc==brk_addr) & ~resume_mask.
- cpu_en (combinational) = (state==STEP) | (state==RUN & ~brk_match).
- brk_hit = (state==BRK), registered via state.
- en_cnt increments by 1 every clock where cpu_en=1; wraps modulo 2^CNT_W.
- PAUSE:
  - run=1 -> RUN.
  - else step_pulse=1 -> STEP, step counter loaded with STEP_CYCLES-1.
  - run and step_pulse in the same cycle: RUN wins, pulse dropped.
- RUN:
  - run=0 -> PAUSE (checked first).
  - else brk_match=1 -> BRK. The matching instruction does not execute: cpu_en=0 in the match cycle.
- STEP:
  - cpu_en=1 for exactly STEP_CYCLES consecutive cycles; counter decrements each cycle; at 0 -> PAUSE.
  - step_pulse and run ignored while in STEP; no queuing.
  - Breakpoints ignored in STEP.
- BRK:
  - cpu_en=0.
  - step_pulse=1 -> STEP, with resume_mask set.
  - else run=0 -> PAUSE, with resume_mask set.
  - run held at 1 with no pulse: stay in BRK.
  - step_pulse and run=0 in the same cycle: STEP.
- resume_mask:
  - Set on any exit from BRK.
  - Cleared on the first clock where pc!=brk_addr, or when brk_en=0.
  - Lets the breakpoint instruction execute on resume, without re-triggering.
- brk_addr or brk_en changes take effect combinationally on brk_match next evaluation; no latching.
- Reset asserted mid-STEP or mid-RUN: immediate return to PAUSE, cpu_en=0, counters cleared.

Test Plan:
- Reset, then run=0 and one step_pulse, STEP_CYCLES=1 -> cpu_en high exactly 1 cycle, state 0->2->0, en_cnt=1.
- STEP_CYCLES=5, step_pulse, then second pulse 2 cycles later -> cpu_en high exactly 5 cycles, second pulse ignored, en_cnt=5.
- run=1 for 10 cycles, brk_en=0, pc incrementing by 4 -> cpu_en high every cycle from cycle after run rises; run=0 -> PAUSE next cycle, en_cnt=10.
- brk_en=1, brk_addr=0x10, run=1, pc 0x0,0x4,0x8,0xC,0x10 -> cpu_en drops in the cycle pc=0x10; state=BRK, brk_hit=1 next cycle; pc holds 0x10.
- From BRK, step_pulse -> one cycle cpu_en=1 while pc=0x10 (mask); pc advances to 0x14, mask clears, state PAUSE. Repeat run=1 with pc wrapping back to 0x10 -> breakpoint hits again.
- run=1 and step_pulse same cycle in PAUSE -> RUN, no STEP entry. Assert rst mid-RUN -> cpu_en=0 immediately, state=0, en_cnt=0.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control inputs and status outputs of the run/step controller.
interface cpu_run_ctrl_if #(parameter int CNT_W = 32);
  logic run;
  logic step_pulse;
  logic brk_en;
  logic [31:0] brk_addr;
  logic [31:0] pc;
  logic cpu_en;
  logic brk_hit;
  logic [1:0] state;
  logic [CNT_W-1:0] en_cnt;
  modport master (output run, step_pulse, brk_en, brk_addr, pc, input cpu_en, brk_hit, state, en_cnt);
  modport slave (input run, step_pulse, brk_en, brk_addr, pc, output cpu_en, brk_hit, state, en_cnt);
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/single-step/breakpoint controller producing the CPU clock enable.
module cpu_run_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  cpu_run_ctrl_if.slave bus
);
  typedef enum logic [1:0] {PAUSE, RUN, STEP, BRK} state_t;
  state_t st;
  logic [7:0] cnt;
  logic mask;
  logic [CNT_W-1:0] en_cnt;
  logic brk_match, cpu_en;
  assign brk_match = bus.brk_en & (bus.pc == bus.brk_addr) & ~mask;
  assign cpu_en = (st == STEP) | ((st == RUN) & ~brk_match);
  assign bus.cpu_en = cpu_en;
  assign bus.brk_hit = (st == BRK);
  assign bus.state = st;
  assign bus.en_cnt = en_cnt;
  // mask lets the halted instruction execute once on resume without re-matching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= PAUSE;
      cnt <= '0;
      mask <= 1'b0;
      en_cnt <= '0;
    end else begin
      if (cpu_en) en_cnt <= en_cnt + 1'b1;
      if (st == BRK && (bus.step_pulse || !bus.run)) mask <= 1'b1;
      else if (!bus.brk_en || bus.pc != bus.brk_addr) mask <= 1'b0;
      case (st)
        PAUSE: if (bus.run) st <= RUN;
               else if (bus.step_pulse) begin
                 st <= STEP;
                 cnt <= 8'(STEP_CYCLES - 1);
               end
        RUN: if (!bus.run) st <= PAUSE;
             else if (brk_match) st <= BRK;
        STEP: if (cnt == 8'd0) st <= PAUSE;
              else cnt <= cnt - 8'd1;
        BRK: if (bus.step_pulse) begin
               st <= STEP;
               cnt <= 8'(STEP_CYCLES - 1);
             end else if (!bus.run) st <= PAUSE;
        default: st <= PAUSE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: two controllers (1- and 5-cycle step) driven identically, scored against a behavioural model.
module tb_cpu_run_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  cpu_run_ctrl_if #(.CNT_W(32)) ia ();
  cpu_run_ctrl_if #(.CNT_W(32)) ib ();
  cpu_run_ctrl #(.STEP_CYCLES(1), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  cpu_run_ctrl #(.STEP_CYCLES(5), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  typedef struct {
    logic en;
    logic hit;
    logic [1:0] st;
    logic [31:0] cnt;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int vectors = 0;
  int miscompares = 0;
  int steps[2] = '{1, 5};
  int mode[2];
  int left[2];
  bit mask[2];
  logic [31:0] ecnt[2];
  logic [31:0] pc_v = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0 && qb.size() > 0) begin
      exp_t ea, eb;
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a.cpu_en", 32'(ia.cpu_en), 32'(ea.en));
      chk("a.brk_hit", 32'(ia.brk_hit), 32'(ea.hit));
      chk("a.state", 32'(ia.state), 32'(ea.st));
      chk("a.en_cnt", ia.en_cnt, ea.cnt);
      chk("b.cpu_en", 32'(ib.cpu_en), 32'(eb.en));
      chk("b.brk_hit", 32'(ib.brk_hit), 32'(eb.hit));
      chk("b.state", 32'(ib.state), 32'(eb.st));
      chk("b.en_cnt", ib.en_cnt, eb.cnt);
    end
  end

  // one clock: apply inputs, publish this cycle's expectation, advance the model
  task automatic cyc(input bit r, input bit run, input bit sp, input bit be, input logic [31:0] ba, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = r;
    ia.run = run; ib.run = run;
    ia.step_pulse = sp; ib.step_pulse = sp;
    ia.brk_en = be; ib.brk_en = be;
    ia.brk_addr = ba; ib.brk_addr = ba;
    ia.pc = pc; ib.pc = pc;
    for (int k = 0; k < 2; k++) begin
      bit hit_bp, en;
      exp_t e;
      if (r) begin
        mode[k] = 0; left[k] = 0; mask[k] = 0; ecnt[k] = 0;
      end
      hit_bp = be && pc == ba && !mask[k];
      en = mode[k] == 2 || (mode[k] == 1 && !hit_bp);
      e.en = en; e.hit = (mode[k] == 3); e.st = 2'(mode[k]); e.cnt = ecnt[k];
      if (k == 0) qa.push_back(e); else qb.push_back(e);
      if (!r) begin
        ecnt[k] += 32'(en);
        if (mode[k] == 3 && (sp || !run)) mask[k] = 1;
        else if (!be || pc != ba) mask[k] = 0;
        case (mode[k])
          0: if (run) mode[k] = 1; else if (sp) begin mode[k] = 2; left[k] = steps[k]; end
          1: if (!run) mode[k] = 0; else if (hit_bp) mode[k] = 3;
          2: begin left[k]--; if (left[k] == 0) mode[k] = 0; end
          default: if (sp) begin mode[k] = 2; left[k] = steps[k]; end else if (!run) mode[k] = 0;
        endcase
      end
    end
  endtask

  initial begin
    ia.run = 0; ib.run = 0; ia.step_pulse = 0; ib.step_pulse = 0;
    ia.brk_en = 0; ib.brk_en = 0; ia.brk_addr = 0; ib.brk_addr = 0; ia.pc = 0; ib.pc = 0;
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, 0, 32'(i * 4));
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 4; i++) cyc(0, 1, 0, 1, 32'h10, 32'(i * 4));
    repeat (3) cyc(0, 1, 0, 1, 32'h10, 32'h10);
    cyc(0, 1, 1, 1, 32'h10, 32'h10);
    cyc(0, 1, 0, 1, 32'h10, 32'h10);
    repeat (6) cyc(0, 0, 0, 1, 32'h10, 32'h14);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 32'h10, 32'h14 + 32'(i * 4) & 32'h1f);
    repeat (2) cyc(0, 0, 0, 1, 32'h10, 32'h10);
    cyc(0, 0, 0, 1, 32'h10, 32'h14);
    cyc(0, 1, 1, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      bit run_r;
      logic [31:0] ba;
      run_r = ($urandom_range(0, 9) < 6);
      ba = 32'h20;
      case ($urandom_range(0, 3))
        0: pc_v = ba;
        1: pc_v = ba + 4;
        2: pc_v = pc_v + 4;
        default: pc_v = 32'($urandom_range(0, 15)) << 2;
      endcase
      cyc(($urandom_range(0, 199) == 0), run_r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0), ba, pc_v);
    end
    repeat (3) @(posedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, expected 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
